// File: rtl/alu_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor:
// lookahead group width, stage count and the add/subtract mode encodings.
package alu_pkg;

  localparam int CLA_GROUP = 16;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int num_stages(input int width);
    return width / CLA_GROUP;
  endfunction

endpackage

// File: rtl/cla_group16.sv
// Combinational 16-bit carry-lookahead group: four 4-bit lookahead blocks
// under a second lookahead level, exporting group generate/propagate.
module cla_group16
  import alu_pkg::*;
(
  input  logic [CLA_GROUP-1:0] A,
  input  logic [CLA_GROUP-1:0] B,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] S,
  output logic                 G,
  output logic                 P,
  output logic                 cout
);

  logic [CLA_GROUP-1:0] gb_s;
  logic [CLA_GROUP-1:0] pb_s;
  logic [CLA_GROUP-1:0] c_s;
  logic [3:0]           bg_s;
  logic [3:0]           bp_s;
  logic [3:0]           bc_s;

  // Two-level lookahead: block G/P, block carries, then bit carries.
  always_comb begin
    gb_s = A & B;
    pb_s = A ^ B;
    bg_s = 4'b0000;
    bp_s = 4'b0000;
    c_s  = {CLA_GROUP{1'b0}};
    for (int j = 0; j < 4; j++) begin
      bg_s[j] = gb_s[4*j+3]
              | (pb_s[4*j+3] & gb_s[4*j+2])
              | (pb_s[4*j+3] & pb_s[4*j+2] & gb_s[4*j+1])
              | (pb_s[4*j+3] & pb_s[4*j+2] & pb_s[4*j+1] & gb_s[4*j]);
      bp_s[j] = &pb_s[4*j +: 4];
    end
    bc_s[0] = cin;
    bc_s[1] = bg_s[0] | (bp_s[0] & cin);
    bc_s[2] = bg_s[1] | (bp_s[1] & bg_s[0]) | (bp_s[1] & bp_s[0] & cin);
    bc_s[3] = bg_s[2] | (bp_s[2] & bg_s[1]) | (bp_s[2] & bp_s[1] & bg_s[0])
            | (bp_s[2] & bp_s[1] & bp_s[0] & cin);
    for (int j = 0; j < 4; j++) begin
      c_s[4*j]   = bc_s[j];
      c_s[4*j+1] = gb_s[4*j] | (pb_s[4*j] & bc_s[j]);
      c_s[4*j+2] = gb_s[4*j+1] | (pb_s[4*j+1] & gb_s[4*j])
                 | (pb_s[4*j+1] & pb_s[4*j] & bc_s[j]);
      c_s[4*j+3] = gb_s[4*j+2] | (pb_s[4*j+2] & gb_s[4*j+1])
                 | (pb_s[4*j+2] & pb_s[4*j+1] & gb_s[4*j])
                 | (pb_s[4*j+2] & pb_s[4*j+1] & pb_s[4*j] & bc_s[j]);
    end
    G    = bg_s[3] | (bp_s[3] & bg_s[2]) | (bp_s[3] & bp_s[2] & bg_s[1])
         | (bp_s[3] & bp_s[2] & bp_s[1] & bg_s[0]);
    P    = &bp_s;
    cout = G | (P & cin);
    S    = pb_s ^ c_s;
  end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// WIDTH-bit add/subtract pipelined as one 16-bit lookahead group per stage,
// with a valid/ready handshake and a single global advance/stall.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NSTAGE = num_stages(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V,
  output logic             Z,
  output logic             N
);

  logic adv_s;
  logic sub_s;

  assign adv_s    = !out_valid | out_ready;
  assign in_ready = adv_s;
  assign sub_s    = (sub == MODE_SUB);

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int DONE = CLA_GROUP * (k + 1);
    localparam int REM  = WIDTH - DONE;

    logic [CLA_GROUP-1:0] a_s, b_s, grp_s;
    logic                 cin_s, vin_s, g_s, p_s, cout_unused_s, carry_d;
    logic [DONE-1:0]      sum_d, sum_q;
    logic                 valid_q, carry_q;

    // Stage 0 takes the ports; later stages take the previous stage's registers.
    if (k == 0) begin : g_src
      assign a_s   = A[CLA_GROUP-1:0];
      assign b_s   = B[CLA_GROUP-1:0] ^ {CLA_GROUP{sub_s}};
      assign cin_s = sub_s;
      assign vin_s = in_valid;
      assign sum_d = grp_s;
    end else begin : g_src
      assign a_s   = g_stage[k-1].g_ops.a_q[CLA_GROUP-1:0];
      assign b_s   = g_stage[k-1].g_ops.b_q[CLA_GROUP-1:0]
                   ^ {CLA_GROUP{g_stage[k-1].g_ops.sub_q}};
      assign cin_s = g_stage[k-1].carry_q;
      assign vin_s = g_stage[k-1].valid_q;
      assign sum_d = {grp_s, g_stage[k-1].sum_q};
    end

    cla_group16 u_cla (
      .A    (a_s),
      .B    (b_s),
      .cin  (cin_s),
      .S    (grp_s),
      .G    (g_s),
      .P    (p_s),
      .cout (cout_unused_s)
    );

    assign carry_d = g_s | (p_s & cin_s);

    // Valid moves with every advance so bubbles drain; data loads only when valid.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= {DONE{1'b0}};
      end else if (adv_s) begin
        valid_q <= vin_s;
        if (vin_s) begin
          carry_q <= carry_d;
          sum_q   <= sum_d;
        end
      end
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_d, b_d, a_q, b_q;
      logic           sub_d, sub_q;

      if (k == 0) begin : g_opsrc
        assign a_d   = A[WIDTH-1:CLA_GROUP];
        assign b_d   = B[WIDTH-1:CLA_GROUP];
        assign sub_d = sub_s;
      end else begin : g_opsrc
        assign a_d   = g_stage[k-1].g_ops.a_q[REM+CLA_GROUP-1:CLA_GROUP];
        assign b_d   = g_stage[k-1].g_ops.b_q[REM+CLA_GROUP-1:CLA_GROUP];
        assign sub_d = g_stage[k-1].g_ops.sub_q;
      end

      // Carry the untouched upper operand slices and the mode to later stages.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q   <= {REM{1'b0}};
          b_q   <= {REM{1'b0}};
          sub_q <= 1'b0;
        end else if (adv_s && vin_s) begin
          a_q   <= a_d;
          b_q   <= b_d;
          sub_q <= sub_d;
        end
      end
    end

    if (k == NSTAGE - 1) begin : g_flags
      logic v_d, z_d, n_d, v_q, z_q, n_q;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      assign v_d = (grp_s[CLA_GROUP-1] ^ a_s[CLA_GROUP-1] ^ b_s[CLA_GROUP-1]) ^ carry_d;
      assign z_d = ~|sum_d;
      assign n_d = grp_s[CLA_GROUP-1];

      // Result flags registered alongside the final sum.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v_q <= 1'b0;
          z_q <= 1'b0;
          n_q <= 1'b0;
        end else if (adv_s && vin_s) begin
          v_q <= v_d;
          z_q <= z_d;
          n_q <= n_d;
        end
      end
    end
  end

  assign out_valid = g_stage[NSTAGE-1].valid_q;
  assign S         = g_stage[NSTAGE-1].sum_q;
  assign C_out     = g_stage[NSTAGE-1].carry_q;
  assign V         = g_stage[NSTAGE-1].g_flags.v_q;
  assign Z         = g_stage[NSTAGE-1].g_flags.z_q;
  assign N         = g_stage[NSTAGE-1].g_flags.n_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for the 32-bit pipelined add/subtract: directed vector table,
// stall/reset sequences and a random handshake stream against a model.
`timescale 1ns/1ps
module tb_pipelined_cla_addsub;

  localparam int W    = 32;
  localparam int NOPS = 3000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0]  A, B, S;
  logic          C_out, V, Z, N;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sb;
    logic [W-1:0] s;
    logic         c, v, z, n;
  } vec_t;

  vec_t vecs[12];

  pipelined_cla_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .C_out     (C_out),
    .V         (V),
    .Z         (Z),
    .N         (N)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [35:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sb);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         v;
    be = b ^ {W{sb}};
    r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, sb};
    v  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return {r[W-1:0], r[W], v, (r[W-1:0] == {W{1'b0}}), r[W-1]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] exp_r;
    logic [35:0] q[$];
    int issued, retired, seen_valid;
    logic acc;

    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = 32'h0; B = 32'h0; sub = 1'b0;
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_result", {28'b0, S, C_out, V, Z, N}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table: one operation at a time, two-cycle latency check.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      A = vecs[i].a; B = vecs[i].b; sub = vecs[i].sb; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1", i), {63'b0, out_valid}, 64'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {63'b0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_result", i), {28'b0, S, C_out, V, Z, N},
          {28'b0, vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n});
    end

    // Back-to-back sets under a four-cycle output stall.
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    A = 32'h1; B = 32'h2; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    A = 32'hA; B = 32'h3; sub = 1'b1;
    @(negedge clk);
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; sub = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("stall%0d_in_ready", c), {63'b0, in_ready}, 64'd0);
      chk($sformatf("stall%0d_hold", c), {31'b0, out_valid, S}, {31'b0, 1'b1, 32'h0000_0003});
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_second", {31'b0, out_valid, S}, {31'b0, 1'b1, 32'h0000_0007});
    @(negedge clk);
    chk("drain_third", {30'b0, out_valid, S, C_out}, {30'b0, 1'b1, 32'hFFFF_FFFE, 1'b1});
    @(negedge clk);
    chk("drain_empty", {63'b0, out_valid}, 64'd0);

    // Reset with two operations in flight.
    A = 32'h1; B = 32'h1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    A = 32'h2; B = 32'h2;
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("async_rst_result", {28'b0, S, C_out, V, Z, N}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    chk("post_rst_no_ghost", 64'(seen_valid), 64'd0);
    A = 32'h0000_FFFF; B = 32'hFFFF_0000; sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {63'b0, out_valid}, 64'd1);
    chk("post_rst_result", {28'b0, S, C_out, V, Z, N},
        {28'b0, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0, 1'b0});

    // Random stream with random back-pressure, scoreboard in acceptance order.
    @(negedge clk);
    issued = 0; retired = 0; acc = 1'b0;
    for (int cyc = 0; cyc < 20000 && retired < NOPS; cyc++) begin
      @(negedge clk);
      if (acc) begin
        in_valid = 1'b0;
        acc = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && issued < NOPS && $urandom_range(0, 3) != 0) begin
        A = $urandom; B = $urandom; sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_out", 64'd1, 64'd0);
        end else begin
          exp_r = q.pop_front();
          chk($sformatf("rand_op%0d", retired), {28'b0, S, C_out, V, Z, N}, {28'b0, exp_r});
          retired++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_add(A, B, sub));
        issued++;
        acc = 1'b1;
      end
    end
    chk("rand_all_retired", 64'(retired), 64'(NOPS));
    chk("rand_queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
